// File: rtl/permutator_round.sv
// ============================================================================
// Module      : permutator_round
// Description : One Ascon permutation round (p_C, p_S, p_L) per clock with a
//               registered 320-bit state. Define PERMUTATOR_CLKEN_EN to add
//               the enable_i load qualifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module permutator_round (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic [319:0] state_in_i,
    input  logic [3:0]   round_i,
    input  logic         input_select_i,
`ifdef PERMUTATOR_CLKEN_EN
    input  logic         enable_i,
`endif
    output logic [319:0] state_out_o
);

    localparam int unsigned c_word_w = 64;

    logic [319:0]        r_state_q;
    logic [319:0]        w_state_d;
    logic [319:0]        w_src;
    logic [319:0]        w_round;
    logic                w_load;
    logic [7:0]          w_rc;
    logic [c_word_w-1:0] w_x0, w_x1, w_x2, w_x3, w_x4;
    logic [c_word_w-1:0] w_t0, w_t1, w_t2, w_t3, w_t4;
    logic [c_word_w-1:0] w_s0, w_s1, w_s2, w_s3, w_s4;

    function automatic logic [c_word_w-1:0] ror64(input logic [c_word_w-1:0] w,
                                                  input int unsigned n);
        return (w >> n) | (w << (c_word_w - n));
    endfunction

`ifdef PERMUTATOR_CLKEN_EN
    assign w_load = enable_i;
`else
    assign w_load = 1'b1;
`endif

    always_comb begin
        w_src = input_select_i ? r_state_q : state_in_i;
        w_rc  = {4'd15 - round_i, round_i};

        w_x0 = w_src[319:256];
        w_x1 = w_src[255:192];
        w_x2 = w_src[191:128] ^ {56'd0, w_rc};
        w_x3 = w_src[127:64];
        w_x4 = w_src[63:0];

        // Bitsliced form of the 5-bit S-box, applied to all 64 columns at once
        w_x0 = w_x0 ^ w_x4;
        w_x4 = w_x4 ^ w_x3;
        w_x2 = w_x2 ^ w_x1;
        w_t0 = ~w_x0 & w_x1;
        w_t1 = ~w_x1 & w_x2;
        w_t2 = ~w_x2 & w_x3;
        w_t3 = ~w_x3 & w_x4;
        w_t4 = ~w_x4 & w_x0;
        w_s0 = w_x0 ^ w_t1;
        w_s1 = w_x1 ^ w_t2;
        w_s2 = w_x2 ^ w_t3;
        w_s3 = w_x3 ^ w_t4;
        w_s4 = w_x4 ^ w_t0;
        w_s1 = w_s1 ^ w_s0;
        w_s0 = w_s0 ^ w_s4;
        w_s3 = w_s3 ^ w_s2;
        w_s2 = ~w_s2;

        w_round = {w_s0 ^ ror64(w_s0, 19) ^ ror64(w_s0, 28),
                   w_s1 ^ ror64(w_s1, 61) ^ ror64(w_s1, 39),
                   w_s2 ^ ror64(w_s2,  1) ^ ror64(w_s2,  6),
                   w_s3 ^ ror64(w_s3, 10) ^ ror64(w_s3, 17),
                   w_s4 ^ ror64(w_s4,  7) ^ ror64(w_s4, 41)};

        w_state_d = w_load ? w_round : r_state_q;
    end

    always_ff @(posedge clock_i) begin
        if (resetb_i) begin
            r_state_q <= '0;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    assign state_out_o = r_state_q;

endmodule

`default_nettype wire

// File: tb/tb_permutator_round.sv
// ============================================================================
// Module      : tb_permutator_round
// Description : Directed self-checking bench for permutator_round.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_permutator_round;

    logic         clock_i = 1'b0;
    logic         resetb_i;
    logic [319:0] state_in_i;
    logic [3:0]   round_i;
    logic         input_select_i;
    logic [319:0] state_out_o;
`ifdef PERMUTATOR_CLKEN_EN
    logic         enable_i;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] SBOX_T [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

    localparam logic [319:0] IV_STATE = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2,
        64'hbe263d4d7aecaaff, 64'h4ed0ec0b98c529b7, 64'hc8cddf37bcd0284a};

    // One round of the zero state, hand-derived for constants 0xF0, 0x0F, 0x96
    localparam logic [319:0] ZERO_R0 = {64'h001E0F00000000F0, 64'h00000001E0000770,
        64'h3FFFFFFFFFFFFF74, 64'h3C780000000000F0, 64'h0000000000000000};
    localparam logic [319:0] ZERO_R15 = {64'h0001E0F00000000F, 64'h000000001E000077,
        64'h43FFFFFFFFFFFFF7, 64'h03C780000000000F, 64'h0000000000000000};
    localparam logic [319:0] ZERO_R6 = {64'h0012C96000000096, 64'h000000012C000426,
        64'hA7FFFFFFFFFFFF20, 64'h25CB000000000096, 64'h0000000000000000};

    permutator_round u_dut (
        .clock_i        (clock_i),
        .resetb_i       (resetb_i),
        .state_in_i     (state_in_i),
        .round_i        (round_i),
        .input_select_i (input_select_i),
`ifdef PERMUTATOR_CLKEN_EN
        .enable_i       (enable_i),
`endif
        .state_out_o    (state_out_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [63:0] rr(input logic [63:0] w, input int n);
        logic [63:0] res;
        for (int i = 0; i < 64; i++) res[i] = w[(i + n) % 64];
        return res;
    endfunction

    // Reference round: table-driven S-box applied column by column
    function automatic logic [319:0] ref_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [3:0]  hi;
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        hi = 4'd15 - r;
        x[2][7:0] = x[2][7:0] ^ {hi, r};
        for (int i = 0; i < 64; i++) begin
            col = SBOX_T[{x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]}];
            y[0][i] = col[4];
            y[1][i] = col[3];
            y[2][i] = col[2];
            y[3][i] = col[1];
            y[4][i] = col[0];
        end
        return {y[0] ^ rr(y[0], 19) ^ rr(y[0], 28),
                y[1] ^ rr(y[1], 61) ^ rr(y[1], 39),
                y[2] ^ rr(y[2],  1) ^ rr(y[2],  6),
                y[3] ^ rr(y[3], 10) ^ rr(y[3], 17),
                y[4] ^ rr(y[4],  7) ^ rr(y[4], 41)};
    endfunction

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    logic [319:0] exp_s;
    logic [319:0] vecs [6];
    logic [3:0]   rnds [6];

    initial begin
        resetb_i       = 1'b1;
        state_in_i     = '1;
        round_i        = 4'd5;
        input_select_i = 1'b1;
`ifdef PERMUTATOR_CLKEN_EN
        enable_i       = 1'b0;
`endif
        tick();
        check_eq("reset", state_out_o, '0);
`ifdef PERMUTATOR_CLKEN_EN
        enable_i = 1'b1;
`endif

        resetb_i = 1'b0; state_in_i = '0; input_select_i = 1'b0; round_i = 4'd0;
        tick();
        check_eq("zero_r0", state_out_o, ZERO_R0);

        round_i = 4'd15;
        tick();
        check_eq("zero_r15", state_out_o, ZERO_R15);

        // Chain of 12 rounds from the IV state
        state_in_i = IV_STATE; input_select_i = 1'b0; round_i = 4'd0;
        tick();
        exp_s = ref_round(IV_STATE, 4'd0);
        check_eq("chain_r0", state_out_o, exp_s);
        input_select_i = 1'b1;
        state_in_i = '0;
        for (int r = 1; r < 12; r++) begin
            round_i = 4'(r);
            tick();
            exp_s = ref_round(exp_s, 4'(r));
            check_eq($sformatf("chain_r%0d", r), state_out_o, exp_s);
        end

        // Reset mid-chain discards it; next round starts from zero
        state_in_i = IV_STATE; input_select_i = 1'b0; round_i = 4'd0;
        tick();
        input_select_i = 1'b1;
        for (int r = 1; r < 5; r++) begin
            round_i = 4'(r);
            tick();
        end
        resetb_i = 1'b1; round_i = 4'd5;
        tick();
        check_eq("reset_mid", state_out_o, '0);
        resetb_i = 1'b0; round_i = 4'd6;
        tick();
        check_eq("zero_r6", state_out_o, ZERO_R6);

        // External source each cycle, including rounds 12..15
        vecs[0] = IV_STATE;      rnds[0] = 4'd3;
        vecs[1] = '1;            rnds[1] = 4'd12;
        vecs[2] = {80{4'hA}};    rnds[2] = 4'd13;
        vecs[3] = {80{4'h5}};    rnds[3] = 4'd14;
        vecs[4] = {5{64'h0123456789ABCDEF}}; rnds[4] = 4'd15;
        vecs[5] = ~IV_STATE;     rnds[5] = 4'd11;
        input_select_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            state_in_i = vecs[i];
            round_i    = rnds[i];
            tick();
            check_eq($sformatf("ext_%0d", i), state_out_o, ref_round(vecs[i], rnds[i]));
        end

`ifdef PERMUTATOR_CLKEN_EN
        state_in_i = IV_STATE; input_select_i = 1'b0; round_i = 4'd0;
        tick();
        exp_s = ref_round(IV_STATE, 4'd0);
        input_select_i = 1'b1;
        for (int r = 1; r < 12; r++) begin
            round_i = 4'(r);
            if (r == 4) begin
                enable_i = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    tick();
                    check_eq($sformatf("hold_%0d", h), state_out_o, exp_s);
                end
                enable_i = 1'b1;
            end
            tick();
            exp_s = ref_round(exp_s, 4'(r));
            check_eq($sformatf("en_chain_r%0d", r), state_out_o, exp_s);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
